// File: rtl/sort_result_checker_if.sv
// Data-memory read port used by the sort result checker.
// The checker is the master; the memory answers one cycle after the strobe.
interface sort_result_checker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (output mem_rd_en, output mem_rd_addr, input mem_rd_data);
  modport slave  (input mem_rd_en, input mem_rd_addr, output mem_rd_data);
endinterface

// File: rtl/sort_result_checker.sv
// End-of-run monitor: counts RUN cycles and flushes, then scans a memory
// window and reports whether it is ordered, how many pairs are not, and where.
module sort_result_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int BASE_ADDR      = 369,
  parameter int NUM_WORDS      = 10,
  parameter int SIGNED         = 1,
  parameter int DESCEND        = 0,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int IDX_WIDTH      = $clog2(NUM_WORDS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_BF,
  input  logic                  start,
  input  logic                  flush_in,
  input  logic                  done_in,
  sort_result_checker_if.master mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [IDX_WIDTH-1:0]  mismatch_count,
  output logic [IDX_WIDTH-1:0]  first_fail_idx,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  typedef enum logic [2:0] {IDLE, RUN, SCAN, DRAIN, REPORT} state_e;

  localparam logic [CNT_WIDTH-1:0]  TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0]  LastIdx     = IDX_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BaseAddr    = ADDR_WIDTH'(BASE_ADDR);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cycleCnt_q, cycleCnt_d;
  logic [CNT_WIDTH-1:0]   misCnt_q, misCnt_d;
  logic                   timeout_q, timeout_d;
  logic [IDX_WIDTH-1:0]   mmCnt_q, mmCnt_d;
  logic [IDX_WIDTH-1:0]   firstFail_q, firstFail_d;
  logic [IDX_WIDTH-1:0]   scanCnt_q, scanCnt_d;
  logic [IDX_WIDTH-1:0]   rxIdx_q, rxIdx_d;
  logic                   rdValid_q;
  logic [DATA_WIDTH-1:0]  prev_q, prev_d;
  logic                   rdEn_q, rdEn_d;
  logic [ADDR_WIDTH-1:0]  rdAddr_q, rdAddr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;

  logic timeoutHit, arm, prevGt, prevLt, violation;

  assign timeoutHit = (cycleCnt_q == TimeoutLast);
  assign arm        = ((state_q == IDLE) || (state_q == REPORT)) && start;

  // Incoming word is compared against the registered previous element.
  assign prevGt = (SIGNED != 0) ? ($signed(prev_q) > $signed(mem.mem_rd_data))
                                : (prev_q > mem.mem_rd_data);
  assign prevLt = (SIGNED != 0) ? ($signed(prev_q) < $signed(mem.mem_rd_data))
                                : (prev_q < mem.mem_rd_data);
  assign violation = (DESCEND != 0) ? prevLt : prevGt;

  always_ff @(posedge clk) begin
    if (rst_BF) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, REPORT: if (start) state_d = RUN;
      RUN:          if (done_in || timeoutHit) state_d = SCAN;
      SCAN:         if (scanCnt_q == LastIdx) state_d = DRAIN;
      DRAIN:        state_d = REPORT;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    cycleCnt_d  = cycleCnt_q;
    misCnt_d    = misCnt_q;
    timeout_d   = timeout_q;
    mmCnt_d     = mmCnt_q;
    firstFail_d = firstFail_q;
    rxIdx_d     = rxIdx_q;
    prev_d      = prev_q;
    scanCnt_d   = '0;

    if (arm) begin
      cycleCnt_d  = '0;
      misCnt_d    = '0;
      timeout_d   = 1'b0;
      mmCnt_d     = '0;
      firstFail_d = '0;
      rxIdx_d     = '0;
    end

    if (state_q == RUN) begin
      if (cycleCnt_q != '1) cycleCnt_d = cycleCnt_q + 1'b1;
      if (flush_in && (misCnt_q != '1)) misCnt_d = misCnt_q + 1'b1;
      if (!done_in && timeoutHit) timeout_d = 1'b1;
    end

    if (state_q == SCAN) scanCnt_d = scanCnt_q + 1'b1;

    if (rdValid_q) begin
      prev_d  = mem.mem_rd_data;
      rxIdx_d = rxIdx_q + 1'b1;
      if ((rxIdx_q != '0) && violation) begin
        mmCnt_d = mmCnt_q + 1'b1;
        if (mmCnt_q == '0) firstFail_d = rxIdx_q;
      end
    end

    // Outputs are decoded from the next state so that they come out registered.
    rdEn_d   = (state_d == SCAN);
    rdAddr_d = rdEn_d ? (BaseAddr + ADDR_WIDTH'(scanCnt_d)) : '0;
    busy_d   = (state_d == RUN) || (state_d == SCAN) || (state_d == DRAIN);
    done_d   = (state_d == REPORT);
    pass_d   = done_d && (mmCnt_d == '0) && !timeout_d;
  end

  always_ff @(posedge clk) begin
    if (rst_BF) begin
      cycleCnt_q  <= '0;
      misCnt_q    <= '0;
      timeout_q   <= 1'b0;
      mmCnt_q     <= '0;
      firstFail_q <= '0;
      scanCnt_q   <= '0;
      rxIdx_q     <= '0;
      rdValid_q   <= 1'b0;
      prev_q      <= '0;
      rdEn_q      <= 1'b0;
      rdAddr_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      cycleCnt_q  <= cycleCnt_d;
      misCnt_q    <= misCnt_d;
      timeout_q   <= timeout_d;
      mmCnt_q     <= mmCnt_d;
      firstFail_q <= firstFail_d;
      scanCnt_q   <= scanCnt_d;
      rxIdx_q     <= rxIdx_d;
      rdValid_q   <= rdEn_q;
      prev_q      <= prev_d;
      rdEn_q      <= rdEn_d;
      rdAddr_q    <= rdAddr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign mem.mem_rd_en    = rdEn_q;
  assign mem.mem_rd_addr  = rdAddr_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign timeout          = timeout_q;
  assign mismatch_count   = mmCnt_q;
  assign first_fail_idx   = firstFail_q;
  assign cycle_count      = cycleCnt_q;
  assign mispredict_count = misCnt_q;

endmodule

// File: tb/tb_sort_result_checker.sv
// Five checker instances with different orderings, timeouts and window sizes
// share one stimulus stream and one memory image; a rule-level model predicts each.
module tb_sort_result_checker;

  localparam int NI   = 5;
  localparam int BASE = 369;
  localparam int MAXP = 6000;
  localparam int NW_P [NI] = '{10, 10, 10, 10, 1};
  localparam int SG_P [NI] = '{1, 1, 0, 1, 1};
  localparam int DS_P [NI] = '{0, 0, 0, 1, 0};
  localparam int TO_P [NI] = '{5000, 50, 5000, 5000, 5000};
  localparam logic [31:0] ASC [10] = '{32'hffffffff, 32'h1, 32'h2, 32'h2, 32'h3,
                                       32'h4, 32'h5, 32'h8, 32'ha, 32'h14};

  logic clk = 1'b0;
  logic rst_BF, start, flush_in, done_in;
  logic [31:0] mem [0:4095];
  bit flushPat [MAXP];
  int checks = 0;
  int errors = 0;

  logic        oBusy [NI];
  logic        oDone [NI];
  logic        oPass [NI];
  logic        oTo   [NI];
  logic        oEn   [NI];
  logic [11:0] oAddr [NI];
  logic [31:0] oCyc  [NI];
  logic [31:0] oMis  [NI];
  logic [31:0] oMm   [NI];
  logic [31:0] oFf   [NI];
  logic [4:0]  mmW   [4];
  logic [4:0]  ffW   [4];
  logic        mm4, ff4;

  always #5 clk = ~clk;

  sort_result_checker_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) mif0 ();
  sort_result_checker_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) mif1 ();
  sort_result_checker_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) mif2 ();
  sort_result_checker_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) mif3 ();
  sort_result_checker_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) mif4 ();

  sort_result_checker u0 (
    .clk(clk), .rst_BF(rst_BF), .start(start), .flush_in(flush_in), .done_in(done_in),
    .mem(mif0), .busy(oBusy[0]), .done(oDone[0]), .pass(oPass[0]), .timeout(oTo[0]),
    .mismatch_count(mmW[0]), .first_fail_idx(ffW[0]),
    .cycle_count(oCyc[0]), .mispredict_count(oMis[0]));

  sort_result_checker #(.TIMEOUT_CYCLES(50)) u1 (
    .clk(clk), .rst_BF(rst_BF), .start(start), .flush_in(flush_in), .done_in(done_in),
    .mem(mif1), .busy(oBusy[1]), .done(oDone[1]), .pass(oPass[1]), .timeout(oTo[1]),
    .mismatch_count(mmW[1]), .first_fail_idx(ffW[1]),
    .cycle_count(oCyc[1]), .mispredict_count(oMis[1]));

  sort_result_checker #(.SIGNED(0)) u2 (
    .clk(clk), .rst_BF(rst_BF), .start(start), .flush_in(flush_in), .done_in(done_in),
    .mem(mif2), .busy(oBusy[2]), .done(oDone[2]), .pass(oPass[2]), .timeout(oTo[2]),
    .mismatch_count(mmW[2]), .first_fail_idx(ffW[2]),
    .cycle_count(oCyc[2]), .mispredict_count(oMis[2]));

  sort_result_checker #(.DESCEND(1)) u3 (
    .clk(clk), .rst_BF(rst_BF), .start(start), .flush_in(flush_in), .done_in(done_in),
    .mem(mif3), .busy(oBusy[3]), .done(oDone[3]), .pass(oPass[3]), .timeout(oTo[3]),
    .mismatch_count(mmW[3]), .first_fail_idx(ffW[3]),
    .cycle_count(oCyc[3]), .mispredict_count(oMis[3]));

  sort_result_checker #(.NUM_WORDS(1)) u4 (
    .clk(clk), .rst_BF(rst_BF), .start(start), .flush_in(flush_in), .done_in(done_in),
    .mem(mif4), .busy(oBusy[4]), .done(oDone[4]), .pass(oPass[4]), .timeout(oTo[4]),
    .mismatch_count(mm4), .first_fail_idx(ff4),
    .cycle_count(oCyc[4]), .mispredict_count(oMis[4]));

  // Memory answers one cycle after the strobe; without a strobe it returns junk.
  always @(posedge clk) mif0.mem_rd_data <= mif0.mem_rd_en ? mem[mif0.mem_rd_addr] : 32'hDEADBEEF;
  always @(posedge clk) mif1.mem_rd_data <= mif1.mem_rd_en ? mem[mif1.mem_rd_addr] : 32'hDEADBEEF;
  always @(posedge clk) mif2.mem_rd_data <= mif2.mem_rd_en ? mem[mif2.mem_rd_addr] : 32'hDEADBEEF;
  always @(posedge clk) mif3.mem_rd_data <= mif3.mem_rd_en ? mem[mif3.mem_rd_addr] : 32'hDEADBEEF;
  always @(posedge clk) mif4.mem_rd_data <= mif4.mem_rd_en ? mem[mif4.mem_rd_addr] : 32'hDEADBEEF;

  assign oEn[0] = mif0.mem_rd_en;  assign oAddr[0] = mif0.mem_rd_addr;
  assign oEn[1] = mif1.mem_rd_en;  assign oAddr[1] = mif1.mem_rd_addr;
  assign oEn[2] = mif2.mem_rd_en;  assign oAddr[2] = mif2.mem_rd_addr;
  assign oEn[3] = mif3.mem_rd_en;  assign oAddr[3] = mif3.mem_rd_addr;
  assign oEn[4] = mif4.mem_rd_en;  assign oAddr[4] = mif4.mem_rd_addr;
  assign oMm[0] = {27'b0, mmW[0]}; assign oFf[0] = {27'b0, ffW[0]};
  assign oMm[1] = {27'b0, mmW[1]}; assign oFf[1] = {27'b0, ffW[1]};
  assign oMm[2] = {27'b0, mmW[2]}; assign oFf[2] = {27'b0, ffW[2]};
  assign oMm[3] = {27'b0, mmW[3]}; assign oFf[3] = {27'b0, ffW[3]};
  assign oMm[4] = {31'b0, mm4};    assign oFf[4] = {31'b0, ff4};

  function automatic longint toVal(input logic [31:0] w, input int sg);
    return (sg != 0) ? longint'($signed(w)) : longint'({32'b0, w});
  endfunction

  // Count adjacent out-of-order pairs in the window and note the first one.
  function automatic void refScan(input int nw, input int sg, input int ds,
                                  output int mm, output int ff);
    longint p, c;
    mm = 0;
    ff = 0;
    for (int k = 1; k < nw; k++) begin
      p = toVal(mem[BASE+k-1], sg);
      c = toVal(mem[BASE+k], sg);
      if ((ds != 0) ? (p < c) : (p > c)) begin
        if (mm == 0) ff = k;
        mm++;
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkReset();
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("u%0d.rst.busy", i), 64'(oBusy[i]), 64'd0);
      checkOutput($sformatf("u%0d.rst.done", i), 64'(oDone[i]), 64'd0);
      checkOutput($sformatf("u%0d.rst.pass", i), 64'(oPass[i]), 64'd0);
      checkOutput($sformatf("u%0d.rst.timeout", i), 64'(oTo[i]), 64'd0);
      checkOutput($sformatf("u%0d.rst.rd_en", i), 64'(oEn[i]), 64'd0);
      checkOutput($sformatf("u%0d.rst.rd_addr", i), 64'(oAddr[i]), 64'd0);
      checkOutput($sformatf("u%0d.rst.mismatch", i), 64'(oMm[i]), 64'd0);
      checkOutput($sformatf("u%0d.rst.first_fail", i), 64'(oFf[i]), 64'd0);
      checkOutput($sformatf("u%0d.rst.cycles", i), 64'(oCyc[i]), 64'd0);
      checkOutput($sformatf("u%0d.rst.mispred", i), 64'(oMis[i]), 64'd0);
    end
  endtask

  task automatic clearFlush();
    for (int j = 0; j < MAXP; j++) flushPat[j] = 1'b0;
  endtask

  task automatic setImage(input bit descending);
    for (int k = 0; k < 10; k++) mem[BASE+k] = descending ? ASC[9-k] : ASC[k];
  endtask

  task automatic makeImage(input bit sorted);
    int v;
    int a;
    v = int'($urandom_range(0, 10)) - 5;
    for (int k = 0; k < 10; k++) begin
      mem[BASE+k] = 32'(v);
      v = v + int'($urandom_range(0, 3));
    end
    if (!sorted) begin
      a = int'($urandom_range(0, 9));
      mem[BASE+a] = $urandom;
    end
  endtask

  // One start-to-report run: done_in in RUN period doneAt (-1 = never),
  // optional extra start pulse at startAt and reset pulse at resetAt.
  task automatic applyStimulus(input int doneAt, input int startAt, input int resetAt);
    int runLen [NI];
    int endP   [NI];
    int expMis [NI];
    int expMm  [NI];
    int expFf  [NI];
    bit expTo  [NI];
    bit seen;
    bit expEn;
    int lastP;
    lastP = 0;
    for (int i = 0; i < NI; i++) begin
      seen      = (doneAt >= 0) && (doneAt < TO_P[i]);
      runLen[i] = seen ? doneAt + 1 : TO_P[i];
      expTo[i]  = !seen;
      endP[i]   = runLen[i] + NW_P[i] + 1;
      expMis[i] = 0;
      for (int j = 0; j < runLen[i]; j++) if (flushPat[j]) expMis[i]++;
      refScan(NW_P[i], SG_P[i], DS_P[i], expMm[i], expFf[i]);
      if (endP[i] + 2 > lastP) lastP = endP[i] + 2;
    end
    if (resetAt >= 0) lastP = resetAt;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j <= lastP; j++) begin
      for (int i = 0; i < NI; i++) begin
        expEn = (j >= runLen[i]) && (j < runLen[i] + NW_P[i]);
        checkOutput($sformatf("u%0d.busy@%0d", i, j), 64'(oBusy[i]), 64'(j < endP[i]));
        checkOutput($sformatf("u%0d.done@%0d", i, j), 64'(oDone[i]), 64'(j >= endP[i]));
        checkOutput($sformatf("u%0d.rd_en@%0d", i, j), 64'(oEn[i]), 64'(expEn));
        if (expEn)
          checkOutput($sformatf("u%0d.rd_addr@%0d", i, j), 64'(oAddr[i]),
                      64'(BASE + j - runLen[i]));
        checkOutput($sformatf("u%0d.cycles@%0d", i, j), 64'(oCyc[i]),
                    64'((j < runLen[i]) ? j : runLen[i]));
        if (j == 0) begin
          checkOutput($sformatf("u%0d.clr.mispred", i), 64'(oMis[i]), 64'd0);
          checkOutput($sformatf("u%0d.clr.mismatch", i), 64'(oMm[i]), 64'd0);
          checkOutput($sformatf("u%0d.clr.timeout", i), 64'(oTo[i]), 64'd0);
        end
      end
      flush_in = flushPat[j];
      done_in  = (j == doneAt);
      start    = (j == startAt);
      rst_BF   = (j == resetAt);
      @(negedge clk);
    end
    flush_in = 1'b0;
    done_in  = 1'b0;
    start    = 1'b0;

    if (resetAt >= 0) begin
      checkReset();
      rst_BF = 1'b0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        checkOutput($sformatf("u%0d.pass", i), 64'(oPass[i]), 64'((expMm[i] == 0) && !expTo[i]));
        checkOutput($sformatf("u%0d.timeout", i), 64'(oTo[i]), 64'(expTo[i]));
        checkOutput($sformatf("u%0d.mismatch", i), 64'(oMm[i]), 64'(expMm[i]));
        checkOutput($sformatf("u%0d.first_fail", i), 64'(oFf[i]), 64'(expFf[i]));
        checkOutput($sformatf("u%0d.mispred", i), 64'(oMis[i]), 64'(expMis[i]));
        checkOutput($sformatf("u%0d.cycles", i), 64'(oCyc[i]), 64'(runLen[i]));
      end
    end
  endtask

  initial begin
    int d;
    int s;
    rst_BF   = 1'b1;
    start    = 1'b0;
    flush_in = 1'b0;
    done_in  = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = $urandom;
    clearFlush();
    repeat (3) @(negedge clk);
    checkReset();
    rst_BF = 1'b0;

    setImage(1'b0);
    applyStimulus(99, -1, -1);

    mem[BASE+5] = 32'h0;
    for (int k = 0; k < 7; k++) flushPat[2 + 3*k] = 1'b1;
    flushPat[31] = 1'b1;
    flushPat[33] = 1'b1;
    flushPat[35] = 1'b1;
    applyStimulus(30, 32, -1);

    clearFlush();
    setImage(1'b1);
    applyStimulus(20, -1, -1);

    setImage(1'b0);
    for (int j = 0; j < 60; j++) flushPat[j] = ($urandom_range(0, 4) == 0);
    applyStimulus(-1, -1, -1);

    applyStimulus(49, -1, -1);

    clearFlush();
    applyStimulus(10, -1, 14);

    for (int r = 0; r < 16; r++) begin
      makeImage(bit'($urandom_range(0, 1)));
      for (int j = 0; j < 200; j++) flushPat[j] = ($urandom_range(0, 3) == 0);
      d = int'($urandom_range(0, 80));
      s = ((d < 48) && ($urandom_range(0, 1) == 1)) ? d + 2 : -1;
      applyStimulus(d, s, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
